forward_hazard_ctrl: RTL and testbench

FORWARD_HAZARD_CTRL -- requirements
Module: forward_hazard_ctrl

---
 rtl/forward_hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_forward_hazard_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/forward_hazard_ctrl.sv
// Operand forwarding, load-use stall and data-cache miss freeze for a 5-stage pipeline.
// Optional statistics counters (lu_stall_cnt, miss_cycle_cnt) are built when FWD_STATS_EN is defined.
module forward_hazard_ctrl #(
  parameter int DATA_SIZE = 32,
  parameter int REG_ADDR  = 5,
  parameter int CNT_SIZE  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_ADDR-1:0]  ID_Rs,
  input  logic [REG_ADDR-1:0]  ID_Rt,
  input  logic [REG_ADDR-1:0]  EX_Rs,
  input  logic [REG_ADDR-1:0]  EX_Rt,
  input  logic [REG_ADDR-1:0]  EX_Rd,
  input  logic                 EX_MemRead,
  input  logic [REG_ADDR-1:0]  MEM_Rd,
  input  logic                 MEM_RegWrite,
  input  logic [REG_ADDR-1:0]  WB_Rd,
  input  logic                 WB_RegWrite,
  input  logic [DATA_SIZE-1:0] EX_Rs_data,
  input  logic [DATA_SIZE-1:0] EX_Rt_data,
  input  logic [DATA_SIZE-1:0] MEM_ALUout,
  input  logic [DATA_SIZE-1:0] WB_out,
  input  logic                 dcache_stall,
  output logic [1:0]           ForwardA,
  output logic [1:0]           ForwardB,
  output logic [DATA_SIZE-1:0] FAout,
  output logic [DATA_SIZE-1:0] FBout,
  output logic                 PC_write,
  output logic                 IF_ID_write,
  output logic                 ID_EX_flush,
  output logic                 pipe_freeze
`ifdef FWD_STATS_EN
  ,
  output logic [CNT_SIZE-1:0]  lu_stall_cnt,
  output logic [CNT_SIZE-1:0]  miss_cycle_cnt
`endif
);

  // state | meaning
  // RUN   | normal flow, operands come from the live forwarding mux
  // MISS  | dcache miss in progress, operands come from the hold registers
  typedef enum logic {RUN = 1'b0, MISS = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [DATA_SIZE-1:0] hold_a_q, hold_a_d, hold_b_q, hold_b_d;
  logic [DATA_SIZE-1:0] live_a, live_b;
  logic                 load_use;
  logic                 lu_stall;

  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR-1:0] src);
    if (MEM_RegWrite && (MEM_Rd != '0) && (MEM_Rd == src))
      return 2'b10;
    else if (WB_RegWrite && (WB_Rd != '0) && (WB_Rd == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    ForwardA = fwd_sel(EX_Rs);
    ForwardB = fwd_sel(EX_Rt);
    case (ForwardA)
      2'b10:   live_a = MEM_ALUout;
      2'b01:   live_a = WB_out;
      default: live_a = EX_Rs_data;
    endcase
    case (ForwardB)
      2'b10:   live_b = MEM_ALUout;
      2'b01:   live_b = WB_out;
      default: live_b = EX_Rt_data;
    endcase
  end

  assign load_use = EX_MemRead && (EX_Rd != '0) && ((EX_Rd == ID_Rs) || (EX_Rd == ID_Rt));

  always_comb begin
    state_d     = state_q;
    hold_a_d    = hold_a_q;
    hold_b_d    = hold_b_q;
    FAout       = live_a;
    FBout       = live_b;
    PC_write    = 1'b1;
    IF_ID_write = 1'b1;
    ID_EX_flush = 1'b0;
    pipe_freeze = dcache_stall;
    lu_stall    = 1'b0;
    if (rst) begin
      pipe_freeze = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (dcache_stall) begin
            state_d     = MISS;
            hold_a_d    = live_a;
            hold_b_d    = live_b;
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
          end else if (load_use) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
            lu_stall    = 1'b1;
          end
        end
        MISS: begin
          FAout = hold_a_q;
          FBout = hold_b_q;
          if (dcache_stall) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
          end else begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      hold_a_q <= '0;
      hold_b_q <= '0;
    end else begin
      state_q  <= state_d;
      hold_a_q <= hold_a_d;
      hold_b_q <= hold_b_d;
    end
  end

`ifdef FWD_STATS_EN
  logic [CNT_SIZE-1:0] lu_cnt_q, miss_cnt_q;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (lu_stall && (lu_cnt_q != '1))
        lu_cnt_q <= lu_cnt_q + 1'b1;
      if (dcache_stall && (miss_cnt_q != '1))
        miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  assign lu_stall_cnt   = lu_cnt_q;
  assign miss_cycle_cnt = miss_cnt_q;
`else
  // CNT_SIZE only sizes the statistics counters; nothing to build here.
  if (CNT_SIZE < 1) begin : g_cnt_size_unused
  end
`endif

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// Scoreboard bench for forward_hazard_ctrl; checks counters too when FWD_STATS_EN is defined.
module tb_forward_hazard_ctrl;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ID_Rs, ID_Rt, EX_Rs, EX_Rt, EX_Rd, MEM_Rd, WB_Rd;
  logic          EX_MemRead, MEM_RegWrite, WB_RegWrite, dcache_stall;
  logic [DW-1:0] EX_Rs_data, EX_Rt_data, MEM_ALUout, WB_out;
  logic [1:0]    ForwardA, ForwardB;
  logic [DW-1:0] FAout, FBout;
  logic          PC_write, IF_ID_write, ID_EX_flush, pipe_freeze;
  logic [CW-1:0] lu_stall_cnt, miss_cycle_cnt;

  int errors = 0;
  int checks = 0;

  forward_hazard_ctrl #(.DATA_SIZE(DW), .REG_ADDR(AW), .CNT_SIZE(CW)) dut (
    .clk(clk), .rst(rst),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt),
    .EX_Rd(EX_Rd), .EX_MemRead(EX_MemRead),
    .MEM_Rd(MEM_Rd), .MEM_RegWrite(MEM_RegWrite),
    .WB_Rd(WB_Rd), .WB_RegWrite(WB_RegWrite),
    .EX_Rs_data(EX_Rs_data), .EX_Rt_data(EX_Rt_data),
    .MEM_ALUout(MEM_ALUout), .WB_out(WB_out),
    .dcache_stall(dcache_stall),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .FAout(FAout), .FBout(FBout),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write),
    .ID_EX_flush(ID_EX_flush), .pipe_freeze(pipe_freeze)
`ifdef FWD_STATS_EN
    , .lu_stall_cnt(lu_stall_cnt), .miss_cycle_cnt(miss_cycle_cnt)
`endif
  );

`ifndef FWD_STATS_EN
  assign lu_stall_cnt   = '0;
  assign miss_cycle_cnt = '0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    fa_sel, fb_sel;
    logic [DW-1:0] fa, fb;
    logic          pcw, ifw, fl, fz;
    logic [CW-1:0] lu, mc;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic          m_miss = 1'b0;
  logic [DW-1:0] m_ha = '0, m_hb = '0;
  logic [CW-1:0] m_lu = '0, m_mc = '0;
  logic [DW-1:0] cur_la, cur_lb;
  logic          cur_lu;

  function automatic logic [1:0] ref_sel(input logic [AW-1:0] src);
    if (MEM_RegWrite && MEM_Rd != 0 && MEM_Rd == src) return 2'b10;
    if (WB_RegWrite && WB_Rd != 0 && WB_Rd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [DW-1:0] ref_mux(input logic [1:0] s, input logic [DW-1:0] rf);
    return (s == 2'b10) ? MEM_ALUout : (s == 2'b01) ? WB_out : rf;
  endfunction

  // One clock: predict, compare at the falling edge, then advance the model on the rising edge.
  task automatic cycle();
    exp_t e, o;
    e.fa_sel = ref_sel(EX_Rs);
    e.fb_sel = ref_sel(EX_Rt);
    cur_la = ref_mux(e.fa_sel, EX_Rs_data);
    cur_lb = ref_mux(e.fb_sel, EX_Rt_data);
    cur_lu = EX_MemRead && EX_Rd != 0 && (EX_Rd == ID_Rs || EX_Rd == ID_Rt);
    e.lu = m_lu;
    e.mc = m_mc;
    if (rst) begin
      e.fa = cur_la; e.fb = cur_lb;
      e.pcw = 1; e.ifw = 1; e.fl = 0; e.fz = 0;
    end else begin
      e.fz = dcache_stall;
      e.fa = m_miss ? m_ha : cur_la;
      e.fb = m_miss ? m_hb : cur_lb;
      if (dcache_stall) begin
        e.pcw = 0; e.ifw = 0; e.fl = 0;
      end else if (!m_miss && cur_lu) begin
        e.pcw = 0; e.ifw = 0; e.fl = 1;
      end else begin
        e.pcw = 1; e.ifw = 1; e.fl = 0;
      end
    end
    exp_q.push_back(e);
    @(negedge clk);
    o = exp_q.pop_front();
    checks += 8;
    if (ForwardA !== o.fa_sel) begin errors++; $display("FAIL ForwardA got=%b exp=%b t=%0t", ForwardA, o.fa_sel, $time); end
    if (ForwardB !== o.fb_sel) begin errors++; $display("FAIL ForwardB got=%b exp=%b t=%0t", ForwardB, o.fb_sel, $time); end
    if (FAout !== o.fa) begin errors++; $display("FAIL FAout got=%h exp=%h t=%0t", FAout, o.fa, $time); end
    if (FBout !== o.fb) begin errors++; $display("FAIL FBout got=%h exp=%h t=%0t", FBout, o.fb, $time); end
    if (PC_write !== o.pcw) begin errors++; $display("FAIL PC_write got=%b exp=%b t=%0t", PC_write, o.pcw, $time); end
    if (IF_ID_write !== o.ifw) begin errors++; $display("FAIL IF_ID_write got=%b exp=%b t=%0t", IF_ID_write, o.ifw, $time); end
    if (ID_EX_flush !== o.fl) begin errors++; $display("FAIL ID_EX_flush got=%b exp=%b t=%0t", ID_EX_flush, o.fl, $time); end
    if (pipe_freeze !== o.fz) begin errors++; $display("FAIL pipe_freeze got=%b exp=%b t=%0t", pipe_freeze, o.fz, $time); end
`ifdef FWD_STATS_EN
    checks += 2;
    if (lu_stall_cnt !== o.lu) begin errors++; $display("FAIL lu_stall_cnt got=%0d exp=%0d t=%0t", lu_stall_cnt, o.lu, $time); end
    if (miss_cycle_cnt !== o.mc) begin errors++; $display("FAIL miss_cycle_cnt got=%0d exp=%0d t=%0t", miss_cycle_cnt, o.mc, $time); end
`endif
    @(posedge clk);
    if (rst) begin
      m_miss = 0; m_ha = '0; m_hb = '0; m_lu = '0; m_mc = '0;
    end else begin
      if (!m_miss && dcache_stall) begin m_ha = cur_la; m_hb = cur_lb; end
      if (!m_miss && !dcache_stall && cur_lu && m_lu != '1) m_lu = m_lu + 1'b1;
      if (dcache_stall && m_mc != '1) m_mc = m_mc + 1'b1;
      m_miss = dcache_stall;
    end
    #1;
  endtask

  task automatic idle();
    rst = 0; dcache_stall = 0;
    ID_Rs = 1; ID_Rt = 2; EX_Rs = 1; EX_Rt = 2; EX_Rd = 0; EX_MemRead = 0;
    MEM_Rd = 0; MEM_RegWrite = 0; WB_Rd = 0; WB_RegWrite = 0;
    EX_Rs_data = 32'h1111_0001; EX_Rt_data = 32'h2222_0002;
    MEM_ALUout = 32'h3333_0003; WB_out = 32'h4444_0004;
  endtask

  task automatic test_reset();
    idle(); rst = 1; dcache_stall = 1;
    #1;
    checks += 3;
    if (pipe_freeze !== 1'b0) begin errors++; $display("FAIL reset_freeze got=%b exp=0", pipe_freeze); end
    if (PC_write !== 1'b1) begin errors++; $display("FAIL reset_pc_write got=%b exp=1", PC_write); end
    if (FAout !== 32'h1111_0001) begin errors++; $display("FAIL reset_faout got=%h exp=11110001", FAout); end
    cycle(); cycle();
    idle(); cycle();
  endtask

  task automatic test_fwd_priority();
    idle();
    MEM_Rd = 3; WB_Rd = 3; EX_Rs = 3; MEM_RegWrite = 1; WB_RegWrite = 1;
    MEM_ALUout = 32'hAA; WB_out = 32'hBB;
    #1;
    checks += 2;
    if (ForwardA !== 2'b10) begin errors++; $display("FAIL mem_prio_sel got=%b exp=10", ForwardA); end
    if (FAout !== 32'hAA) begin errors++; $display("FAIL mem_prio_data got=%h exp=aa", FAout); end
    cycle();
    MEM_RegWrite = 0; cycle();
    EX_Rt = 3; cycle();
    WB_RegWrite = 0; cycle();
    MEM_Rd = 4; EX_Rt = 4; MEM_RegWrite = 1; WB_RegWrite = 1; cycle();
  endtask

  task automatic test_zero_reg();
    idle();
    MEM_Rd = 0; EX_Rt = 0; MEM_RegWrite = 1; EX_Rt_data = 32'h55;
    WB_Rd = 0; WB_RegWrite = 1;
    #1;
    checks += 2;
    if (ForwardB !== 2'b00) begin errors++; $display("FAIL zero_reg_sel got=%b exp=00", ForwardB); end
    if (FBout !== 32'h55) begin errors++; $display("FAIL zero_reg_data got=%h exp=55", FBout); end
    cycle();
  endtask

  task automatic test_load_use();
    idle();
    EX_MemRead = 1; EX_Rd = 7; ID_Rt = 7;
    #1;
    checks += 1;
    if (ID_EX_flush !== 1'b1) begin errors++; $display("FAIL load_use_flush got=%b exp=1", ID_EX_flush); end
    cycle();
    idle(); cycle();
    EX_MemRead = 1; EX_Rd = 1; ID_Rs = 1; cycle();
    EX_Rd = 0; ID_Rs = 0; cycle();
    idle(); EX_MemRead = 0; EX_Rd = 2; cycle();
  endtask

  task automatic test_miss_hold();
    idle();
    EX_Rs = 5; MEM_Rd = 5; MEM_RegWrite = 1; MEM_ALUout = 32'h1234;
    dcache_stall = 1;
    cycle();
    for (int i = 0; i < 3; i++) begin
      MEM_ALUout = 32'h9000 + i; EX_Rt_data = $urandom;
      #1;
      checks += 2;
      if (FAout !== 32'h1234) begin errors++; $display("FAIL miss_hold got=%h exp=1234", FAout); end
      if (pipe_freeze !== 1'b1) begin errors++; $display("FAIL miss_freeze got=%b exp=1", pipe_freeze); end
      cycle();
    end
    dcache_stall = 0; MEM_ALUout = 32'h7777;
    cycle(); cycle();
  endtask

  task automatic test_miss_vs_load_use();
    idle();
    EX_MemRead = 1; EX_Rd = 2; ID_Rt = 2; dcache_stall = 1;
    cycle(); cycle();
    dcache_stall = 0; cycle();
    #1;
    checks += 1;
    if (ID_EX_flush !== 1'b1) begin errors++; $display("FAIL flush_after_miss got=%b exp=1", ID_EX_flush); end
    cycle();
    idle(); cycle();
  endtask

  task automatic test_rst_in_miss();
    idle();
    EX_Rs = 6; WB_Rd = 6; WB_RegWrite = 1; WB_out = 32'hCAFE;
    dcache_stall = 1; cycle();
    WB_out = 32'hBEEF; rst = 1; cycle();
    rst = 0; dcache_stall = 0; WB_out = 32'hD00D;
    #1;
    checks += 2;
    if (FAout !== 32'hD00D) begin errors++; $display("FAIL rst_abort_live got=%h exp=d00d", FAout); end
`ifdef FWD_STATS_EN
    if (miss_cycle_cnt !== '0) begin errors++; $display("FAIL rst_abort_cnt got=%0d exp=0", miss_cycle_cnt); end
`else
    if (pipe_freeze !== 1'b0) begin errors++; $display("FAIL rst_abort_freeze got=%b exp=0", pipe_freeze); end
`endif
    cycle();
    dcache_stall = 1; cycle();
    WB_out = 32'h0; cycle();
    dcache_stall = 0; cycle(); cycle();
  endtask

  task automatic test_back_to_back();
    idle();
    for (int i = 0; i < 20; i++) begin
      dcache_stall = (i % 3 != 2);
      EX_MemRead = 1; EX_Rd = 1; ID_Rs = 1;
      MEM_ALUout = i;
      cycle();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) dcache_stall = ~dcache_stall;
      ID_Rs = $urandom_range(0, 3); ID_Rt = $urandom_range(0, 3);
      EX_Rs = $urandom_range(0, 3); EX_Rt = $urandom_range(0, 3);
      EX_Rd = $urandom_range(0, 3); EX_MemRead = $urandom_range(0, 1);
      MEM_Rd = $urandom_range(0, 3); MEM_RegWrite = $urandom_range(0, 1);
      WB_Rd = $urandom_range(0, 3); WB_RegWrite = $urandom_range(0, 1);
      EX_Rs_data = $urandom; EX_Rt_data = $urandom;
      MEM_ALUout = $urandom; WB_out = $urandom;
      cycle();
    end
  endtask

  initial begin
    idle(); rst = 1;
    @(posedge clk); #1;
    test_reset();
    test_fwd_priority();
    test_zero_reg();
    test_load_use();
    test_miss_hold();
    test_miss_vs_load_use();
    test_rst_in_miss();
    test_back_to_back();
    test_random();
    checks += 1;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
